xgemac_rx_pkt_reader: RTL and testbench

Synthesizable reader for the XGEMAC receive packet interface. It waits for `pkt_rx_avail` and drives `pkt_rx_ren` to pull one complete frame per read burst. Words go through a small FIFO to a valid/ready stream with backpressure, and the block keeps packet, byte and error statistics. It sits on the 156.25 MHz user side of the MAC, opposite the MAC's receive FIFO.

---
 rtl/xgemac_rx_pkt_reader.sv | 211 +++++++++++++++++++++
 tb/tb_xgemac_rx_pkt_reader.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xgemac_rx_pkt_reader.sv
// xgemac_rx_pkt_reader
// Pulls complete frames from the XGEMAC receive packet interface one read
// burst at a time. Received words pass through a small FIFO to a valid/ready
// stream. The block also keeps packet, byte and error counters and a sticky
// flag for interface protocol violations.
module xgemac_rx_pkt_reader #(
  parameter int DEPTH = 4
) (
  input  logic        clk_156m25,
  input  logic        reset_156m25_n,
  input  logic        pkt_rx_avail,
  output logic        pkt_rx_ren,
  input  logic [63:0] pkt_rx_data,
  input  logic        pkt_rx_val,
  input  logic        pkt_rx_sop,
  input  logic        pkt_rx_eop,
  input  logic [2:0]  pkt_rx_mod,
  input  logic        pkt_rx_err,
  output logic [63:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sop,
  output logic        out_eop,
  output logic        out_err,
  output logic [2:0]  out_mod,
  input  logic        stat_clr,
  output logic [31:0] stat_pkt_cnt,
  output logic [31:0] stat_byte_cnt,
  output logic [15:0] stat_err_cnt,
  output logic        proto_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int EW = 70;  // {err, mod[2:0], eop, sop, data[63:0]}
  // A read may only be issued while one more in-flight word still fits.
  localparam logic [CW-1:0] REN_MAX = CW'(DEPTH - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] head;
  logic          push, pop;
  logic          eop_in;

  logic          first_q;     // next valid word in this burst should carry sop
  logic          ren_q;       // read enable issued in the previous cycle
  logic          violation;

  logic [31:0]   pkt_cnt_q, byte_cnt_q;
  logic [15:0]   err_cnt_q;
  logic          proto_q;
  logic [31:0]   byte_inc;

  assign eop_in = pkt_rx_val && pkt_rx_eop;

  // FSM state register
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and read enable; the eop word itself blocks further reads
  always_comb begin
    state_d    = state_q;
    pkt_rx_ren = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pkt_rx_avail) begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        pkt_rx_ren = (count_q <= REN_MAX) && !eop_in;
        if (eop_in) begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        // one cycle for the MAC to refresh pkt_rx_avail
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO control: every valid ingress word is stored, pops follow the handshake
  assign push     = pkt_rx_val;
  assign pop      = out_valid && out_ready;
  assign wr_entry = {pkt_rx_err, pkt_rx_mod, pkt_rx_eop, pkt_rx_sop, pkt_rx_data};

  // FIFO occupancy next state
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  // FIFO storage; cleared on reset so the stream outputs read as zero
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign out_data  = head[63:0];
  assign out_sop   = head[64];
  assign out_eop   = head[65];
  assign out_mod   = head[68:66];
  assign out_err   = head[69];
  assign out_valid = (count_q != '0);

  // Bytes contributed by the current ingress word; mod 0 on eop means 8
  always_comb begin
    byte_inc = 32'd8;
    if (pkt_rx_eop && (pkt_rx_mod != 3'd0)) begin
      byte_inc = {29'd0, pkt_rx_mod};
    end
  end

  // Any valid word outside a read burst, unrequested, or with a misplaced sop
  assign violation = pkt_rx_val &&
                     ((state_q != S_READ) || !ren_q || (first_q != pkt_rx_sop));

  // Burst tracking for protocol checking
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      first_q <= 1'b1;
      ren_q   <= 1'b0;
    end else begin
      ren_q <= pkt_rx_ren;
      if (state_q != S_READ) begin
        first_q <= 1'b1;
      end else if (pkt_rx_val) begin
        first_q <= 1'b0;
      end
    end
  end

  // Statistics and sticky protocol flag; a clear beats a coincident update
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      pkt_cnt_q  <= '0;
      byte_cnt_q <= '0;
      err_cnt_q  <= '0;
      proto_q    <= 1'b0;
    end else if (stat_clr) begin
      pkt_cnt_q  <= '0;
      byte_cnt_q <= '0;
      err_cnt_q  <= '0;
      proto_q    <= 1'b0;
    end else begin
      if (pkt_rx_val) begin
        byte_cnt_q <= byte_cnt_q + byte_inc;
      end
      if (eop_in) begin
        pkt_cnt_q <= pkt_cnt_q + 32'd1;
        if (pkt_rx_err) begin
          err_cnt_q <= err_cnt_q + 16'd1;
        end
      end
      if (violation) begin
        proto_q <= 1'b1;
      end
    end
  end

  assign stat_pkt_cnt  = pkt_cnt_q;
  assign stat_byte_cnt = byte_cnt_q;
  assign stat_err_cnt  = err_cnt_q;
  assign proto_err     = proto_q;

endmodule

// File: tb/tb_xgemac_rx_pkt_reader.sv
// Bench for xgemac_rx_pkt_reader: a MAC-side frame source answering each
// read enable one cycle later, a queue-based model of the egress stream and
// arithmetic models of the counters, compared every cycle on the falling edge.
module tb_xgemac_rx_pkt_reader;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pkt_rx_avail;
  logic        pkt_rx_ren;
  logic [63:0] pkt_rx_data;
  logic        pkt_rx_val;
  logic        pkt_rx_sop;
  logic        pkt_rx_eop;
  logic [2:0]  pkt_rx_mod;
  logic        pkt_rx_err;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sop;
  logic        out_eop;
  logic        out_err;
  logic [2:0]  out_mod;
  logic        stat_clr;
  logic [31:0] stat_pkt_cnt;
  logic [31:0] stat_byte_cnt;
  logic [15:0] stat_err_cnt;
  logic        proto_err;

  always #5 clk = ~clk;

  xgemac_rx_pkt_reader #(.DEPTH(DEPTH)) dut (
    .clk_156m25     (clk),
    .reset_156m25_n (rst_n),
    .pkt_rx_avail   (pkt_rx_avail),
    .pkt_rx_ren     (pkt_rx_ren),
    .pkt_rx_data    (pkt_rx_data),
    .pkt_rx_val     (pkt_rx_val),
    .pkt_rx_sop     (pkt_rx_sop),
    .pkt_rx_eop     (pkt_rx_eop),
    .pkt_rx_mod     (pkt_rx_mod),
    .pkt_rx_err     (pkt_rx_err),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_sop        (out_sop),
    .out_eop        (out_eop),
    .out_err        (out_err),
    .out_mod        (out_mod),
    .stat_clr       (stat_clr),
    .stat_pkt_cnt   (stat_pkt_cnt),
    .stat_byte_cnt  (stat_byte_cnt),
    .stat_err_cnt   (stat_err_cnt),
    .proto_err      (proto_err)
  );

  typedef struct {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
    logic        err;
    int          len;
  } word_t;

  word_t mac_q[$];   // words the MAC still holds, whole frames in order
  word_t exp_q[$];   // words that must appear on the egress stream

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int ren_cnt = 0;
  int post_eop = 0;
  int out_words = 0;
  int frame_words = 0;
  int t_avail = -1, t_ren = -1, t_val = -1, t_ov = -1;

  logic [31:0] exp_pkt, exp_bytes;
  logic [15:0] exp_errc;
  logic        exp_proto;
  logic [2:0]  last_mod;
  logic        last_err;

  logic ren_s = 1'b0;
  logic rand_rdy = 1'b0, rdy_fixed = 1'b1, rand_clr = 1'b0;
  logic force_clr = 1'b0, clr_on_eop = 1'b0, inject = 1'b0, viol = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic add_frame(input int len, input logic [2:0] mod, input logic err);
    word_t w;
    for (int i = 0; i < len; i++) begin
      w.data = {$urandom, $urandom};
      w.sop  = (i == 0);
      w.eop  = (i == len - 1);
      w.mod  = w.eop ? mod : 3'd0;
      w.err  = w.eop ? err : 1'b0;
      w.len  = len;
      mac_q.push_back(w);
    end
  endtask

  // Reference behaviour for the edge just taken, from the inputs held before it
  task automatic model_update();
    word_t w, d;
    if (exp_q.size() != 0 && out_ready) d = exp_q.pop_front();
    if (pkt_rx_val) begin
      w.data = pkt_rx_data; w.sop = pkt_rx_sop; w.eop = pkt_rx_eop;
      w.mod = pkt_rx_mod; w.err = pkt_rx_err; w.len = 0;
      exp_q.push_back(w);
    end
    if (stat_clr) begin
      exp_pkt = 0; exp_bytes = 0; exp_errc = 0; exp_proto = 1'b0;
    end else begin
      if (pkt_rx_val && !pkt_rx_eop) exp_bytes = exp_bytes + 32'd8;
      if (pkt_rx_val && pkt_rx_eop) begin
        exp_pkt   = exp_pkt + 32'd1;
        exp_errc  = exp_errc + 16'(pkt_rx_err);
        exp_bytes = exp_bytes + ((pkt_rx_mod == 3'd0) ? 32'd8 : 32'(pkt_rx_mod));
      end
      if (viol) exp_proto = 1'b1;
    end
    viol = 1'b0;
  endtask

  // MAC side and downstream side stimulus for the coming cycle
  task automatic drive();
    word_t w;
    pkt_rx_val = 1'b0; pkt_rx_sop = 1'b0; pkt_rx_eop = 1'b0;
    pkt_rx_mod = 3'd0; pkt_rx_err = 1'b0;
    pkt_rx_data = {$urandom, $urandom};
    stat_clr = force_clr || (rand_clr && ($urandom_range(0, 39) == 0));
    force_clr = 1'b0;
    if (ren_s) begin
      if (mac_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL read_overrun: ren with no word left, expected no read (cycle %0d)", cyc);
      end else begin
        w = mac_q.pop_front();
        pkt_rx_val = 1'b1; pkt_rx_data = w.data; pkt_rx_sop = w.sop;
        pkt_rx_eop = w.eop; pkt_rx_mod = w.mod; pkt_rx_err = w.err;
        if (t_val < 0) t_val = cyc;
        if (w.eop) begin
          chk("ren_per_frame", 64'(ren_cnt), 64'(w.len));
          ren_cnt  = 0;
          post_eop = 3;
          if (clr_on_eop) begin
            stat_clr = 1'b1;
            clr_on_eop = 1'b0;
          end
        end
      end
    end
    if (inject) begin
      pkt_rx_val = 1'b1; pkt_rx_sop = 1'b1; pkt_rx_eop = 1'b1;
      pkt_rx_mod = 3'd3; pkt_rx_err = 1'b0; pkt_rx_data = 64'h0123_4567_89ab_cdef;
      inject = 1'b0; viol = 1'b1;
    end
    pkt_rx_avail = (mac_q.size() != 0);
    if (pkt_rx_avail && t_avail < 0) t_avail = cyc;
    out_ready = rand_rdy ? ($urandom_range(0, 99) < 70) : rdy_fixed;
  endtask

  task automatic compare();
    word_t e;
    if (pkt_rx_ren && t_ren < 0) t_ren = cyc;
    if (out_valid && t_ov < 0) t_ov = cyc;
    if (post_eop > 0) begin
      chk("ren_in_gap", 64'(pkt_rx_ren), 64'd0);
      post_eop--;
    end
    if (exp_q.size() > DEPTH - 2) chk("ren_fifo_gate", 64'(pkt_rx_ren), 64'd0);
    if (mac_q.size() == 0) chk("ren_without_frame", 64'(pkt_rx_ren), 64'd0);
    if (pkt_rx_ren) ren_cnt++;
    chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      e = exp_q[0];
      chk("out_data", out_data, e.data);
      chk("out_sop", 64'(out_sop), 64'(e.sop));
      chk("out_eop", 64'(out_eop), 64'(e.eop));
      chk("out_mod", 64'(out_mod), 64'(e.mod));
      chk("out_err", 64'(out_err), 64'(e.err));
      if (out_ready) begin
        out_words++;
        frame_words++;
        if (e.eop) begin
          last_mod = out_mod;
          last_err = out_err;
          $display("frame out: %0d words, mod=%0d err=%0d (cycle %0d)",
                   frame_words, out_mod, out_err, cyc);
          frame_words = 0;
        end
      end
    end
    chk("stat_pkt_cnt", 64'(stat_pkt_cnt), 64'(exp_pkt));
    chk("stat_byte_cnt", 64'(stat_byte_cnt), 64'(exp_bytes));
    chk("stat_err_cnt", 64'(stat_err_cnt), 64'(exp_errc));
    chk("proto_err", 64'(proto_err), 64'(exp_proto));
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    if (rst_n) model_update();
    #1;
    drive();
    @(negedge clk);
    compare();
    ren_s = pkt_rx_ren;
  endtask

  task automatic wait_idle(input int limit, input string name);
    int k = 0;
    while (!(mac_q.size() == 0 && exp_q.size() == 0 && post_eop == 0) && k < limit) begin
      step();
      k++;
    end
    if (k >= limit) begin
      n_chk++; n_fail++;
      $display("FAIL %s_timeout: still busy after %0d cycles, expected drained", name, limit);
    end
    step();
    step();
  endtask

  task automatic clear_stats();
    force_clr = 1'b1;
    step();
    step();
    out_words = 0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    mac_q.delete();
    exp_pkt = 0; exp_bytes = 0; exp_errc = 0; exp_proto = 1'b0;
    ren_s = 1'b0; ren_cnt = 0; post_eop = 0; viol = 1'b0;
    out_words = 0; frame_words = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    pkt_rx_avail = 1'b0; pkt_rx_data = '0; pkt_rx_val = 1'b0; pkt_rx_sop = 1'b0;
    pkt_rx_eop = 1'b0; pkt_rx_mod = '0; pkt_rx_err = 1'b0;
    out_ready = 1'b1; stat_clr = 1'b0;
    model_reset();
    last_mod = '0; last_err = 1'b0;

    // reset state
    repeat (3) step();
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_flags", {59'd0, out_sop, out_eop, out_err, out_mod}, 64'd0);
    rst_n = 1'b1;
    step();

    // 64-byte frame, ready held high, with start-up latency
    rdy_fixed = 1'b1;
    add_frame(8, 3'd0, 1'b0);
    wait_idle(100, "t1");
    chk("t1_ren_latency", 64'(t_ren - t_avail), 64'd1);
    chk("t1_val_latency", 64'(t_val - t_avail), 64'd2);
    chk("t1_out_latency", 64'(t_ov - t_avail), 64'd3);
    chk("t1_words", 64'(out_words), 64'd8);
    chk("t1_pkt", 64'(stat_pkt_cnt), 64'd1);
    chk("t1_bytes", 64'(stat_byte_cnt), 64'd64);
    chk("t1_proto", 64'(proto_err), 64'd0);

    // 61-byte frame
    clear_stats();
    add_frame(8, 3'd5, 1'b0);
    wait_idle(100, "t2");
    chk("t2_bytes", 64'(stat_byte_cnt), 64'd61);
    chk("t2_pkt", 64'(stat_pkt_cnt), 64'd1);
    chk("t2_mod", 64'(last_mod), 64'd5);

    // 16-word frame against a stalled sink
    clear_stats();
    rdy_fixed = 1'b0;
    add_frame(16, 3'd0, 1'b0);
    repeat (30) step();
    chk("t3_stall_bytes", 64'(stat_byte_cnt), 64'd32);
    chk("t3_stall_ren", 64'(pkt_rx_ren), 64'd0);
    chk("t3_stall_valid", 64'(out_valid), 64'd1);
    rdy_fixed = 1'b1;
    wait_idle(200, "t3");
    chk("t3_words", 64'(out_words), 64'd16);
    chk("t3_bytes", 64'(stat_byte_cnt), 64'd128);

    // errored frame
    clear_stats();
    add_frame(3, 3'd0, 1'b1);
    wait_idle(100, "t4");
    chk("t4_err_cnt", 64'(stat_err_cnt), 64'd1);
    chk("t4_out_err", 64'(last_err), 64'd1);
    chk("t4_bytes", 64'(stat_byte_cnt), 64'd24);

    // clear coinciding with the eop word
    clear_stats();
    clr_on_eop = 1'b1;
    add_frame(4, 3'd2, 1'b1);
    wait_idle(100, "t5a");
    chk("t5_pkt_cleared", 64'(stat_pkt_cnt), 64'd0);
    chk("t5_bytes_cleared", 64'(stat_byte_cnt), 64'd0);
    chk("t5_err_cleared", 64'(stat_err_cnt), 64'd0);
    add_frame(2, 3'd0, 1'b0);
    wait_idle(100, "t5b");
    chk("t5_next_pkt", 64'(stat_pkt_cnt), 64'd1);

    // reset in the middle of a frame
    add_frame(8, 3'd0, 1'b0);
    begin
      int k = 0;
      while (mac_q.size() > 5 && k < 50) begin
        step();
        k++;
      end
    end
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_ren", 64'(pkt_rx_ren), 64'd0);
    chk("t6_rst_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_data", out_data, 64'd0);
    pkt_rx_val = 1'b0; pkt_rx_avail = 1'b0;
    model_reset();
    repeat (3) step();
    rst_n = 1'b1;
    add_frame(8, 3'd0, 1'b0);
    wait_idle(100, "t6");
    chk("t6_words", 64'(out_words), 64'd8);
    chk("t6_pkt", 64'(stat_pkt_cnt), 64'd1);
    chk("t6_bytes", 64'(stat_byte_cnt), 64'd64);
    chk("t6_proto", 64'(proto_err), 64'd0);

    // unsolicited word while idle
    clear_stats();
    inject = 1'b1;
    step();
    step();
    chk("t7_proto_set", 64'(proto_err), 64'd1);
    chk("t7_bytes", 64'(stat_byte_cnt), 64'd3);
    wait_idle(20, "t7");
    clear_stats();
    chk("t7_proto_clr", 64'(proto_err), 64'd0);

    // randomized back-to-back frames, random sink and random clears
    rand_rdy = 1'b1;
    rand_clr = 1'b1;
    for (int i = 0; i < 30; i++) begin
      add_frame($urandom_range(1, 20), 3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0));
    end
    wait_idle(4000, "rand_a");
    rand_clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      add_frame($urandom_range(1, 12), 3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 6)) step();
    end
    wait_idle(2000, "rand_b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
